pipeline_stage_regs: RTL and testbench

- Inter-stage register bank of the 5-stage CPU pipeline, grouping three register sets:
  - ID/EX: decode → execute (existing PipelineMem role).
  - EX/MEM: execute → memory (existing PipelineEx role).
  - MEM/WB: memory → writeback (existing PipelineWB role).
- Each set samples its inputs on the rising clock edge and presents them to the next stage one cycle later.
- ID/EX additionally supports stall (hold) and flush (bubble insertion) for hazard handling.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/pipe_reg.sv | 25 ++
 rtl/pipeline_stage_regs.sv | 187 ++++++++++++++++++
 tb/tb_pipeline_stage_regs.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths and per-stage control bundle types for the CPU pipeline.
package cpu_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned JMPF_W   = 2;
  localparam int unsigned ALUINS_W = 3;

  // Decode -> execute control bundle; every field is cleared by a flush.
  typedef struct packed {
    logic                wmem;
    logic                rmem;
    logic                wreg;
    logic                wpc;
    logic [JMPF_W-1:0]   jmpf;
    logic [ALUINS_W-1:0] aluins;
  } idex_ctrl_t;

  // Execute -> memory control bundle.
  typedef struct packed {
    logic wmem;
    logic rmem;
    logic wreg;
  } exmem_ctrl_t;

  // Memory -> writeback control bundle.
  typedef struct packed {
    logic wreg;
  } memwb_ctrl_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline flop: async active-low reset to 0, synchronous clear
// (takes priority over hold), and a hold enable.
module pipe_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register with clear-over-hold priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipeline_stage_regs.sv
// Inter-stage register bank of the 5-stage pipeline: ID/EX (with stall and
// flush), EX/MEM and MEM/WB. The sets are not chained here; the enclosing
// datapath wires one stage's outputs into the next stage's inputs.
module pipeline_stage_regs
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned REG_W  = cpu_pkg::REG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                idex_stall,
  input  logic                idex_flush,
  // ID/EX inputs
  input  logic                id_wmem,
  input  logic                id_rmem,
  input  logic                id_wreg,
  input  logic                id_wpc,
  input  logic [JMPF_W-1:0]   id_jmpf,
  input  logic [ALUINS_W-1:0] id_aluins,
  input  logic [DATA_W-1:0]   id_r2res,
  input  logic [DATA_W-1:0]   id_r3res,
  input  logic [REG_W-1:0]    id_r2,
  input  logic [REG_W-1:0]    id_r3,
  input  logic [REG_W-1:0]    id_destr,
  // ID/EX outputs
  output logic                ex_wmem,
  output logic                ex_rmem,
  output logic                ex_wreg,
  output logic                ex_wpc,
  output logic [JMPF_W-1:0]   ex_jmpf,
  output logic [ALUINS_W-1:0] ex_aluins,
  output logic [DATA_W-1:0]   ex_r2res,
  output logic [DATA_W-1:0]   ex_r3res,
  output logic [REG_W-1:0]    ex_r2,
  output logic [REG_W-1:0]    ex_r3,
  output logic [REG_W-1:0]    ex_destr,
  // EX/MEM inputs
  input  logic                exm_wmem,
  input  logic                exm_rmem,
  input  logic                exm_wreg,
  input  logic [DATA_W-1:0]   exm_alures,
  input  logic [DATA_W-1:0]   exm_r3res,
  input  logic [REG_W-1:0]    exm_destr,
  // EX/MEM outputs
  output logic                mem_wmem,
  output logic                mem_rmem,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_alures,
  output logic [DATA_W-1:0]   mem_r3res,
  output logic [REG_W-1:0]    mem_destr,
  // MEM/WB inputs
  input  logic                wb_wreg_in,
  input  logic [DATA_W-1:0]   wb_res_in,
  input  logic [REG_W-1:0]    wb_destr_in,
  // MEM/WB outputs
  output logic                wb_wreg,
  output logic [DATA_W-1:0]   wb_res,
  output logic [REG_W-1:0]    wb_destr
);

  localparam int unsigned IDEX_DW  = 2 * DATA_W + 3 * REG_W;
  localparam int unsigned EXMEM_DW = 2 * DATA_W + REG_W;
  localparam int unsigned MEMWB_DW = DATA_W + REG_W;

  // ---------------------------------------------------------------- ID/EX
  idex_ctrl_t           id_ctrl;
  idex_ctrl_t           ex_ctrl;
  logic [IDEX_DW-1:0]   id_data;
  logic [IDEX_DW-1:0]   ex_data;
  logic                 idex_data_hold;

  // Bundle decode-stage control and data fields.
  always_comb begin
    id_ctrl        = '0;
    id_ctrl.wmem   = id_wmem;
    id_ctrl.rmem   = id_rmem;
    id_ctrl.wreg   = id_wreg;
    id_ctrl.wpc    = id_wpc;
    id_ctrl.jmpf   = id_jmpf;
    id_ctrl.aluins = id_aluins;
    id_data        = {id_r2res, id_r3res, id_r2, id_r3, id_destr};
  end

  // A flush must still load the data fields even when a stall is also
  // asserted, so the data hold is masked by flush rather than reusing stall.
  assign idex_data_hold = idex_stall & ~idex_flush;

  pipe_reg #(.W($bits(idex_ctrl_t))) u_idex_ctrl (
    .clk   (clk),
    .rst_n (rst),
    .hold  (idex_stall),
    .clr   (idex_flush),
    .d     (id_ctrl),
    .q     (ex_ctrl)
  );

  pipe_reg #(.W(IDEX_DW)) u_idex_data (
    .clk   (clk),
    .rst_n (rst),
    .hold  (idex_data_hold),
    .clr   (1'b0),
    .d     (id_data),
    .q     (ex_data)
  );

  assign ex_wmem   = ex_ctrl.wmem;
  assign ex_rmem   = ex_ctrl.rmem;
  assign ex_wreg   = ex_ctrl.wreg;
  assign ex_wpc    = ex_ctrl.wpc;
  assign ex_jmpf   = ex_ctrl.jmpf;
  assign ex_aluins = ex_ctrl.aluins;
  assign {ex_r2res, ex_r3res, ex_r2, ex_r3, ex_destr} = ex_data;

  // --------------------------------------------------------------- EX/MEM
  exmem_ctrl_t          exm_ctrl;
  exmem_ctrl_t          mem_ctrl;
  logic [EXMEM_DW-1:0]  exm_data;
  logic [EXMEM_DW-1:0]  mem_data;

  // Bundle execute-stage results.
  always_comb begin
    exm_ctrl      = '0;
    exm_ctrl.wmem = exm_wmem;
    exm_ctrl.rmem = exm_rmem;
    exm_ctrl.wreg = exm_wreg;
    exm_data      = {exm_alures, exm_r3res, exm_destr};
  end

  pipe_reg #(.W($bits(exmem_ctrl_t))) u_exmem_ctrl (
    .clk   (clk),
    .rst_n (rst),
    .hold  (1'b0),
    .clr   (1'b0),
    .d     (exm_ctrl),
    .q     (mem_ctrl)
  );

  pipe_reg #(.W(EXMEM_DW)) u_exmem_data (
    .clk   (clk),
    .rst_n (rst),
    .hold  (1'b0),
    .clr   (1'b0),
    .d     (exm_data),
    .q     (mem_data)
  );

  assign mem_wmem = mem_ctrl.wmem;
  assign mem_rmem = mem_ctrl.rmem;
  assign mem_wreg = mem_ctrl.wreg;
  assign {mem_alures, mem_r3res, mem_destr} = mem_data;

  // --------------------------------------------------------------- MEM/WB
  memwb_ctrl_t          wbi_ctrl;
  memwb_ctrl_t          wbo_ctrl;
  logic [MEMWB_DW-1:0]  wbi_data;
  logic [MEMWB_DW-1:0]  wbo_data;

  // Bundle writeback-stage inputs.
  always_comb begin
    wbi_ctrl      = '0;
    wbi_ctrl.wreg = wb_wreg_in;
    wbi_data      = {wb_res_in, wb_destr_in};
  end

  pipe_reg #(.W($bits(memwb_ctrl_t))) u_memwb_ctrl (
    .clk   (clk),
    .rst_n (rst),
    .hold  (1'b0),
    .clr   (1'b0),
    .d     (wbi_ctrl),
    .q     (wbo_ctrl)
  );

  pipe_reg #(.W(MEMWB_DW)) u_memwb_data (
    .clk   (clk),
    .rst_n (rst),
    .hold  (1'b0),
    .clr   (1'b0),
    .d     (wbi_data),
    .q     (wbo_data)
  );

  assign wb_wreg = wbo_ctrl.wreg;
  assign {wb_res, wb_destr} = wbo_data;

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Directed bench for pipeline_stage_regs.
module tb_pipeline_stage_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        idex_stall, idex_flush;
  logic        id_wmem, id_rmem, id_wreg, id_wpc;
  logic [1:0]  id_jmpf;
  logic [2:0]  id_aluins;
  logic [31:0] id_r2res, id_r3res;
  logic [3:0]  id_r2, id_r3, id_destr;
  logic        ex_wmem, ex_rmem, ex_wreg, ex_wpc;
  logic [1:0]  ex_jmpf;
  logic [2:0]  ex_aluins;
  logic [31:0] ex_r2res, ex_r3res;
  logic [3:0]  ex_r2, ex_r3, ex_destr;
  logic        exm_wmem, exm_rmem, exm_wreg;
  logic [31:0] exm_alures, exm_r3res;
  logic [3:0]  exm_destr;
  logic        mem_wmem, mem_rmem, mem_wreg;
  logic [31:0] mem_alures, mem_r3res;
  logic [3:0]  mem_destr;
  logic        wb_wreg_in;
  logic [31:0] wb_res_in;
  logic [3:0]  wb_destr_in;
  logic        wb_wreg;
  logic [31:0] wb_res;
  logic [3:0]  wb_destr;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  always #5 clk = ~clk;

  pipeline_stage_regs #(.DATA_W(32), .REG_W(4)) dut (
    .clk(clk), .rst(rst), .idex_stall(idex_stall), .idex_flush(idex_flush),
    .id_wmem(id_wmem), .id_rmem(id_rmem), .id_wreg(id_wreg), .id_wpc(id_wpc),
    .id_jmpf(id_jmpf), .id_aluins(id_aluins), .id_r2res(id_r2res),
    .id_r3res(id_r3res), .id_r2(id_r2), .id_r3(id_r3), .id_destr(id_destr),
    .ex_wmem(ex_wmem), .ex_rmem(ex_rmem), .ex_wreg(ex_wreg), .ex_wpc(ex_wpc),
    .ex_jmpf(ex_jmpf), .ex_aluins(ex_aluins), .ex_r2res(ex_r2res),
    .ex_r3res(ex_r3res), .ex_r2(ex_r2), .ex_r3(ex_r3), .ex_destr(ex_destr),
    .exm_wmem(exm_wmem), .exm_rmem(exm_rmem), .exm_wreg(exm_wreg),
    .exm_alures(exm_alures), .exm_r3res(exm_r3res), .exm_destr(exm_destr),
    .mem_wmem(mem_wmem), .mem_rmem(mem_rmem), .mem_wreg(mem_wreg),
    .mem_alures(mem_alures), .mem_r3res(mem_r3res), .mem_destr(mem_destr),
    .wb_wreg_in(wb_wreg_in), .wb_res_in(wb_res_in), .wb_destr_in(wb_destr_in),
    .wb_wreg(wb_wreg), .wb_res(wb_res), .wb_destr(wb_destr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic wm, input logic rm, input logic wr, input logic wp,
                        input logic [1:0] jf, input logic [2:0] al,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] r2, input logic [3:0] r3, input logic [3:0] d);
    id_wmem = wm; id_rmem = rm; id_wreg = wr; id_wpc = wp;
    id_jmpf = jf; id_aluins = al; id_r2res = a; id_r3res = b;
    id_r2 = r2; id_r3 = r3; id_destr = d;
  endtask

  task automatic set_exm(input logic c, input logic [31:0] alu, input logic [31:0] st,
                         input logic [3:0] d);
    exm_wmem = c; exm_rmem = c; exm_wreg = c;
    exm_alures = alu; exm_r3res = st; exm_destr = d;
  endtask

  task automatic set_wb(input logic w, input logic [31:0] r, input logic [3:0] d);
    wb_wreg_in = w; wb_res_in = r; wb_destr_in = d;
  endtask

  task automatic check_ex_ctrl(input string tag, input logic c, input logic [1:0] jf,
                               input logic [2:0] al);
    check({tag, ".wmem"}, ex_wmem, c);
    check({tag, ".rmem"}, ex_rmem, c);
    check({tag, ".wreg"}, ex_wreg, c);
    check({tag, ".wpc"}, ex_wpc, c);
    check({tag, ".jmpf"}, ex_jmpf, jf);
    check({tag, ".aluins"}, ex_aluins, al);
  endtask

  task automatic check_all_zero(input string tag);
    check_ex_ctrl(tag, 1'b0, 2'd0, 3'd0);
    check({tag, ".ex_r2res"}, ex_r2res, 0);
    check({tag, ".ex_r3res"}, ex_r3res, 0);
    check({tag, ".ex_r2"}, ex_r2, 0);
    check({tag, ".ex_r3"}, ex_r3, 0);
    check({tag, ".ex_destr"}, ex_destr, 0);
    check({tag, ".mem_ctl"}, {mem_wmem, mem_rmem, mem_wreg}, 0);
    check({tag, ".mem_alures"}, mem_alures, 0);
    check({tag, ".mem_r3res"}, mem_r3res, 0);
    check({tag, ".mem_destr"}, mem_destr, 0);
    check({tag, ".wb_wreg"}, wb_wreg, 0);
    check({tag, ".wb_res"}, wb_res, 0);
    check({tag, ".wb_destr"}, wb_destr, 0);
  endtask

  task automatic check_std_vector(input string tag);
    check_ex_ctrl(tag, 1'b1, 2'd3, 3'd7);
    check({tag, ".ex_r2res"}, ex_r2res, 18);
    check({tag, ".ex_r3res"}, ex_r3res, 4);
    check({tag, ".ex_r2"}, ex_r2, 5);
    check({tag, ".ex_r3"}, ex_r3, 5);
    check({tag, ".ex_destr"}, ex_destr, 7);
    check({tag, ".mem_ctl"}, {mem_wmem, mem_rmem, mem_wreg}, 3'b111);
    check({tag, ".mem_alures"}, mem_alures, 1);
    check({tag, ".mem_r3res"}, mem_r3res, 1);
    check({tag, ".mem_destr"}, mem_destr, 7);
    check({tag, ".wb_wreg"}, wb_wreg, 1);
    check({tag, ".wb_res"}, wb_res, 1);
    check({tag, ".wb_destr"}, wb_destr, 7);
  endtask

  initial begin
    logic [31:0] prev_r2res, prev_wb;

    rst = 1'b0;
    idex_stall = 1'b0;
    idex_flush = 1'b0;
    set_id(0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 0, 0, 0);
    set_exm(0, 0, 0, 0);
    set_wb(0, 0, 0);

    // Reset held across edges, then with nonzero inputs.
    tick();
    check_all_zero("rst_idle");
    set_id(1, 1, 1, 1, 2'd3, 3'd7, 18, 4, 5, 5, 7);
    set_exm(1, 1, 1, 7);
    set_wb(1, 1, 7);
    tick();
    check_all_zero("rst_held");

    // Release mid-cycle: outputs remain 0 until the first edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("pre_edge");
    tick();
    check_std_vector("first_load");

    // Inputs changing between edges must not reach the outputs.
    set_exm(0, 32'h77, 32'h66, 4'd2);
    set_wb(0, 32'h55, 4'd3);
    id_r2res = 32'h44;
    #2;
    check("nocomb.mem_alures", mem_alures, 1);
    check("nocomb.wb_res", wb_res, 1);
    check("nocomb.ex_r2res", ex_r2res, 18);
    tick();
    check("load2.mem_alures", mem_alures, 32'h77);
    check("load2.mem_ctl", {mem_wmem, mem_rmem, mem_wreg}, 3'b000);
    check("load2.wb_res", wb_res, 32'h55);
    check("load2.wb_destr", wb_destr, 3);
    check("load2.ex_r2res", ex_r2res, 32'h44);

    // Stall: ID/EX holds for three edges; EX/MEM keeps loading.
    id_r2res = 18;
    tick();
    check("stall_pre.ex_r2res", ex_r2res, 18);
    idex_stall = 1'b1;
    id_r2res = 99;
    id_aluins = 3'd2;
    for (int i = 0; i < 3; i++) begin
      exm_alures = 32'(100 + i);
      tick();
      check("stall.ex_r2res", ex_r2res, 18);
      check("stall.ex_aluins", ex_aluins, 7);
      check("stall.mem_alures", mem_alures, 32'(100 + i));
    end
    idex_stall = 1'b0;
    tick();
    check("unstall.ex_r2res", ex_r2res, 99);
    check("unstall.ex_aluins", ex_aluins, 2);

    // Flush alone: controls cleared, data loads, other stages unaffected.
    set_id(1, 1, 1, 1, 2'd3, 3'd7, 32'h1234, 32'h5678, 4'd9, 4'd10, 4'd11);
    set_exm(1, 32'hA1, 32'hA2, 4'd12);
    set_wb(1, 32'hB1, 4'd13);
    idex_flush = 1'b1;
    tick();
    check_ex_ctrl("flush", 1'b0, 2'd0, 3'd0);
    check("flush.ex_r2res", ex_r2res, 32'h1234);
    check("flush.ex_r3res", ex_r3res, 32'h5678);
    check("flush.ex_destr", ex_destr, 11);
    check("flush.mem_ctl", {mem_wmem, mem_rmem, mem_wreg}, 3'b111);
    check("flush.mem_alures", mem_alures, 32'hA1);
    check("flush.wb_wreg", wb_wreg, 1);
    check("flush.wb_res", wb_res, 32'hB1);

    // Normal load, then flush with stall: flush wins.
    idex_flush = 1'b0;
    id_r2res = 32'hAAAA;
    tick();
    check_ex_ctrl("preflush2", 1'b1, 2'd3, 3'd7);
    check("preflush2.ex_r2res", ex_r2res, 32'hAAAA);
    idex_flush = 1'b1;
    idex_stall = 1'b1;
    id_r2res = 32'hBBBB;
    id_r2 = 4'd1;
    tick();
    check_ex_ctrl("flush_stall", 1'b0, 2'd0, 3'd0);
    check("flush_stall.ex_r2res", ex_r2res, 32'hBBBB);
    check("flush_stall.ex_r2", ex_r2, 1);
    check("flush_stall.mem_ctl", {mem_wmem, mem_rmem, mem_wreg}, 3'b111);
    idex_flush = 1'b0;
    idex_stall = 1'b0;

    // Random traffic, each value checked one edge later.
    prev_r2res = $urandom;
    prev_wb = $urandom;
    id_r2res = prev_r2res;
    wb_res_in = prev_wb;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rand.ex_r2res", ex_r2res, prev_r2res);
      check("rand.wb_res", wb_res, prev_wb);
      prev_r2res = $urandom;
      prev_wb = $urandom;
      id_r2res = prev_r2res;
      wb_res_in = prev_wb;
      exm_alures = $urandom;
    end
    tick();

    // Asynchronous reset mid-cycle.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    check_all_zero("async_rst_held");

    // Recovery on the first edge after release.
    @(negedge clk);
    set_id(1, 1, 1, 1, 2'd3, 3'd7, 18, 4, 5, 5, 7);
    set_exm(1, 1, 1, 7);
    set_wb(1, 1, 7);
    rst = 1'b1;
    #1;
    check("recover_pre.ex_r2res", ex_r2res, 0);
    tick();
    check_std_vector("recover");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
